// File: rtl/xrog_orbit_interaction_engine_if.sv
// Lookup stream between a requester and the orbit interaction engine:
// request channel (pair + tag) and response channel (policy + status flags).
interface xrog_orbit_interaction_engine_if #(
    parameter int ORBIT_W = 8,
    parameter int STR_W   = 32,
    parameter int MASK_W  = 8,
    parameter int TAG_W   = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [ORBIT_W-1:0] req_a;
    logic [ORBIT_W-1:0] req_b;
    logic [TAG_W-1:0]   req_tag;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [STR_W-1:0]   rsp_strength;
    logic [STR_W-1:0]   rsp_coupling;
    logic [MASK_W-1:0]  rsp_allowed;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_hit;
    logic               rsp_oob;

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_strength, rsp_coupling,
               rsp_allowed, rsp_tag, rsp_hit, rsp_oob
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_strength, rsp_coupling,
               rsp_allowed, rsp_tag, rsp_hit, rsp_oob
    );
endinterface

// File: rtl/xrog_orbit_interaction_engine.sv
// Programmable orbit-pair policy table with a tagged valid/ready lookup stream,
// a clear-sweep FSM and saturating lookup/miss statistics.
module xrog_orbit_interaction_engine #(
    parameter int ORBIT_W    = 8,
    parameter int NUM_ORBITS = 8,
    parameter int STR_W      = 32,
    parameter int MASK_W     = 8,
    parameter int TAG_W      = 4,
    parameter int SYMMETRIC  = 1,
    parameter int DEF_STR    = 500,
    parameter int DEF_CPL    = 50,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [ORBIT_W-1:0]  cfg_a,
    input  logic [ORBIT_W-1:0]  cfg_b,
    input  logic [STR_W-1:0]    cfg_strength,
    input  logic [STR_W-1:0]    cfg_coupling,
    input  logic [MASK_W-1:0]   cfg_mask,
    input  logic                cfg_clear,
    output logic                busy,
    xrog_orbit_interaction_engine_if.slave lk,
    output logic [CNT_W-1:0]    lookup_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    localparam int unsigned N_ORB = NUM_ORBITS;
    localparam int unsigned CELLS = N_ORB * N_ORB;
    localparam int          IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    typedef struct packed {
        logic             oob;
        logic [IDX_W-1:0] idx;
    } slot_t;

    // Symmetric tables fold (a,b) and (b,a) onto the (min,max) cell.
    function automatic slot_t map_slot(input logic [ORBIT_W-1:0] a, input logic [ORBIT_W-1:0] b);
        int unsigned ai;
        int unsigned bi;
        int unsigned lo;
        int unsigned hi;
        slot_t       s;
        ai    = 32'(a);
        bi    = 32'(b);
        s.oob = (ai >= N_ORB) || (bi >= N_ORB);
        if ((SYMMETRIC != 0) && (ai > bi)) begin
            lo = bi;
            hi = ai;
        end else begin
            lo = ai;
            hi = bi;
        end
        s.idx = IDX_W'(lo * N_ORB + hi);
        return s;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [IDX_W-1:0] w_sweep_nxt;

    logic             r_valid [CELLS];
    logic [STR_W-1:0] r_str   [CELLS];
    logic [STR_W-1:0] r_cpl   [CELLS];
    logic [MASK_W-1:0] r_mask [CELLS];

    logic              r_rsp_valid;
    logic [STR_W-1:0]  r_rsp_strength;
    logic [STR_W-1:0]  r_rsp_coupling;
    logic [MASK_W-1:0] r_rsp_allowed;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic              r_rsp_hit;
    logic              r_rsp_oob;
    logic [CNT_W-1:0]  r_lookup_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    slot_t w_req_slot;
    slot_t w_cfg_slot;
    logic  w_req_ready;
    logic  w_accept;
    logic  w_hit;
    logic  w_cfg_wr;

    assign w_req_slot  = map_slot(lk.req_a, lk.req_b);
    assign w_cfg_slot  = map_slot(cfg_a, cfg_b);
    assign w_req_ready = (r_state == ST_IDLE) && (!r_rsp_valid || lk.rsp_ready);
    assign w_accept    = lk.req_valid && w_req_ready;
    assign w_hit       = !w_req_slot.oob && r_valid[w_req_slot.idx];
    // A clear request wins over a simultaneous write.
    assign w_cfg_wr    = cfg_we && !w_cfg_slot.oob && (r_state == ST_IDLE) && !cfg_clear;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        case (r_state)
            ST_CLEAR: begin
                if (cfg_clear) begin
                    w_sweep_nxt = '0;
                end else if (r_sweep_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (cfg_clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_sweep_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_sweep_nxt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
        end
    end

    // NOTE: the table is RAM-style with no reset; the sweep invalidates entries after reset instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_valid[r_sweep_idx] <= 1'b0;
        end else if (w_cfg_wr) begin
            r_valid[w_cfg_slot.idx] <= 1'b1;
            r_str[w_cfg_slot.idx]   <= cfg_strength;
            r_cpl[w_cfg_slot.idx]   <= cfg_coupling;
            r_mask[w_cfg_slot.idx]  <= cfg_mask;
        end
    end

    // Lookup reads the table before this edge's write lands: read-before-write on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_strength <= '0;
            r_rsp_coupling <= '0;
            r_rsp_allowed  <= '0;
            r_rsp_tag      <= '0;
            r_rsp_hit      <= 1'b0;
            r_rsp_oob      <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_strength <= w_hit ? r_str[w_req_slot.idx]  : STR_W'(DEF_STR);
            r_rsp_coupling <= w_hit ? r_cpl[w_req_slot.idx]  : STR_W'(DEF_CPL);
            r_rsp_allowed  <= w_hit ? r_mask[w_req_slot.idx] : '0;
            r_rsp_tag      <= lk.req_tag;
            r_rsp_hit      <= w_hit;
            r_rsp_oob      <= w_req_slot.oob;
        end else if (lk.rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lookup_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_accept) begin
            if (r_lookup_cnt != '1) r_lookup_cnt <= r_lookup_cnt + 1'b1;
            if (!w_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign busy            = (r_state == ST_CLEAR);
    assign lk.req_ready    = w_req_ready;
    assign lk.rsp_valid    = r_rsp_valid;
    assign lk.rsp_strength = r_rsp_strength;
    assign lk.rsp_coupling = r_rsp_coupling;
    assign lk.rsp_allowed  = r_rsp_allowed;
    assign lk.rsp_tag      = r_rsp_tag;
    assign lk.rsp_hit      = r_rsp_hit;
    assign lk.rsp_oob      = r_rsp_oob;
    assign lookup_cnt      = r_lookup_cnt;
    assign miss_cnt        = r_miss_cnt;
endmodule

// File: tb/tb_xrog_orbit_interaction_engine.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against a pair-keyed policy model.
module tb_xrog_orbit_interaction_engine;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_a, cfg_b;
    logic [31:0] cfg_strength, cfg_coupling;
    logic [7:0]  cfg_mask;
    logic        cfg_clear;
    logic        busy, busy_s;
    logic [15:0] lookup_cnt, miss_cnt;
    logic [2:0]  lookup_cnt_s, miss_cnt_s;

    always #5 clk = ~clk;

    xrog_orbit_interaction_engine_if #(.ORBIT_W(8), .STR_W(32), .MASK_W(8), .TAG_W(4)) bus ();
    xrog_orbit_interaction_engine_if #(.ORBIT_W(8), .STR_W(32), .MASK_W(8), .TAG_W(4)) bus_s ();

    assign bus_s.req_valid = bus.req_valid;
    assign bus_s.req_a     = bus.req_a;
    assign bus_s.req_b     = bus.req_b;
    assign bus_s.req_tag   = bus.req_tag;
    assign bus_s.rsp_ready = bus.rsp_ready;

    xrog_orbit_interaction_engine dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_strength(cfg_strength), .cfg_coupling(cfg_coupling), .cfg_mask(cfg_mask),
        .cfg_clear(cfg_clear), .busy(busy), .lk(bus),
        .lookup_cnt(lookup_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy on the same traffic to reach counter saturation quickly.
    xrog_orbit_interaction_engine #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_strength(cfg_strength), .cfg_coupling(cfg_coupling), .cfg_mask(cfg_mask),
        .cfg_clear(cfg_clear), .busy(busy_s), .lk(bus_s),
        .lookup_cnt(lookup_cnt_s), .miss_cnt(miss_cnt_s)
    );

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] c;
        logic [7:0]  m;
    } pol_t;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] c;
        logic [7:0]  m;
        logic [3:0]  tag;
        logic        hit;
        logic        oob;
    } rsp_t;

    typedef struct {
        int         a;
        int         b;
        logic [3:0] tag;
        rsp_t       exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   e_lk     = 0;
    int   e_ms     = 0;
    pol_t m_tab [int];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pkey(input int a, input int b);
        return (a < b) ? a * 1000 + b : b * 1000 + a;
    endfunction

    function automatic rsp_t model_lookup(input int a, input int b, input logic [3:0] tag);
        rsp_t r;
        r = '{s: 32'd500, c: 32'd50, m: 8'h00, tag: tag, hit: 1'b0, oob: 1'b0};
        if (a >= N || b >= N) r.oob = 1'b1;
        else if (m_tab.exists(pkey(a, b))) begin
            r.s   = m_tab[pkey(a, b)].s;
            r.c   = m_tab[pkey(a, b)].c;
            r.m   = m_tab[pkey(a, b)].m;
            r.hit = 1'b1;
        end
        return r;
    endfunction

    task automatic model_count(input rsp_t r);
        e_lk++;
        if (!r.hit) e_ms++;
    endtask

    task automatic model_write(input int a, input int b, input pol_t p);
        if (a < N && b < N) m_tab[pkey(a, b)] = p;
    endtask

    function automatic rsp_t dut_rsp();
        return {bus.rsp_strength, bus.rsp_coupling, bus.rsp_allowed, bus.rsp_tag, bus.rsp_hit, bus.rsp_oob};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int b, input logic [31:0] s, input logic [31:0] c, input logic [7:0] m);
        cfg_we = 1'b1; cfg_a = 8'(a); cfg_b = 8'(b);
        cfg_strength = s; cfg_coupling = c; cfg_mask = m;
        step();
        cfg_we = 1'b0;
        model_write(a, b, '{s, c, m});
    endtask

    // Single lookup with rsp_ready held high; result compared with the model.
    task automatic lookup_model(input string name, input int a, input int b, input logic [3:0] tag);
        rsp_t exp;
        bus.req_valid = 1'b1; bus.req_a = 8'(a); bus.req_b = 8'(b); bus.req_tag = tag;
        bus.rsp_ready = 1'b1;
        exp = model_lookup(a, b, tag);
        step();
        bus.req_valid = 1'b0;
        model_count(exp);
        check({name, "_valid"}, bus.rsp_valid, 1);
        check(name, dut_rsp(), exp);
    endtask

    task automatic measure_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(name, n, 64);
    endtask

    vec_t vecs [10];

    initial begin
        int   n;
        int   ready_err;
        int   sent;
        int   last_c;
        logic acc, cons;
        logic [3:0] rx [$];
        logic m_rsp_valid;
        rsp_t m_rsp;
        int   ra, rb;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_a = '0; cfg_b = '0;
        cfg_strength = '0; cfg_coupling = '0; cfg_mask = '0; cfg_clear = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b1;
        #20;
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", dut_rsp(), 0);
        check("reset_lookup_cnt", lookup_cnt, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        check("reset_busy", busy, 1);
        check("reset_req_ready", bus.req_ready, 0);
        #3 rst_n = 1'b1;

        // Post-reset sweep length and readiness.
        n = 0; ready_err = 0;
        while (busy && n < 200) begin
            if (bus.req_ready) ready_err++;
            step();
            n++;
        end
        check("sweep_cycles", n, 64);
        check("ready_during_sweep", ready_err, 0);
        check("busy_after_sweep", busy, 0);
        check("ready_after_sweep", bus.req_ready, 1);

        // Vector table.
        do_write(1, 2, 32'd600, 32'd30, 8'h01);
        do_write(7, 0, 32'd1000, 32'd0, 8'h80);
        do_write(3, 8, 32'd123, 32'd45, 8'h67);
        vecs[0] = '{2, 1, 4'd5,  '{32'd600,  32'd30, 8'h01, 4'd5,  1'b1, 1'b0}};
        vecs[1] = '{1, 2, 4'd6,  '{32'd600,  32'd30, 8'h01, 4'd6,  1'b1, 1'b0}};
        vecs[2] = '{3, 4, 4'd1,  '{32'd500,  32'd50, 8'h00, 4'd1,  1'b0, 1'b0}};
        vecs[3] = '{9, 0, 4'd2,  '{32'd500,  32'd50, 8'h00, 4'd2,  1'b0, 1'b1}};
        vecs[4] = '{0, 7, 4'd3,  '{32'd1000, 32'd0,  8'h80, 4'd3,  1'b1, 1'b0}};
        vecs[5] = '{7, 0, 4'd4,  '{32'd1000, 32'd0,  8'h80, 4'd4,  1'b1, 1'b0}};
        vecs[6] = '{4, 0, 4'd7,  '{32'd500,  32'd50, 8'h00, 4'd7,  1'b0, 1'b0}};
        vecs[7] = '{0, 8, 4'd8,  '{32'd500,  32'd50, 8'h00, 4'd8,  1'b0, 1'b1}};
        vecs[8] = '{7, 7, 4'd9,  '{32'd500,  32'd50, 8'h00, 4'd9,  1'b0, 1'b0}};
        vecs[9] = '{255, 255, 4'd15, '{32'd500, 32'd50, 8'h00, 4'd15, 1'b0, 1'b1}};
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1; bus.req_a = 8'(vecs[i].a); bus.req_b = 8'(vecs[i].b);
            bus.req_tag = vecs[i].tag; bus.rsp_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_ready", i), bus.req_ready, 1);
            step();
            bus.req_valid = 1'b0;
            model_count(model_lookup(vecs[i].a, vecs[i].b, vecs[i].tag));
            check($sformatf("vec%0d_valid", i), bus.rsp_valid, 1);
            check($sformatf("vec%0d_rsp", i), dut_rsp(), vecs[i].exp);
            check($sformatf("vec%0d_lookup_cnt", i), lookup_cnt, e_lk);
            check($sformatf("vec%0d_miss_cnt", i), miss_cnt, e_ms);
            if (i == 3) check("miss_cnt_after_oob", miss_cnt, 2);
        end
        step();
        check("rsp_valid_drops", bus.rsp_valid, 0);

        // Backpressure: stall three cycles, then drain one response per cycle.
        sent = 0; last_c = -1;
        bus.req_a = 8'd1; bus.req_b = 8'd2;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.req_valid = (sent < 6);
            bus.req_tag   = 4'(sent + 1);
            bus.rsp_ready = (cyc >= 4);
            #1;
            if (cyc >= 1 && cyc <= 3) begin
                check("stall_ready", bus.req_ready, 0);
                check("stall_valid", bus.rsp_valid, 1);
                check("stall_rsp", dut_rsp(), model_lookup(1, 2, 4'd1));
            end
            acc  = bus.req_valid && bus.req_ready;
            cons = bus.rsp_valid && bus.rsp_ready;
            if (cons) begin
                rx.push_back(bus.rsp_tag);
                last_c = cyc;
            end
            if (acc) begin
                sent++;
                model_count(model_lookup(1, 2, 4'd0));
            end
            step();
        end
        bus.req_valid = 1'b0;
        check("stream_count", rx.size(), 6);
        for (int i = 0; i < rx.size(); i++) check($sformatf("stream_tag%0d", i), rx[i], i + 1);
        check("stream_last_cycle", last_c, 9);
        bus.rsp_ready = 1'b1;

        // Write/lookup collision returns the old contents.
        do_write(2, 3, 32'd111, 32'd11, 8'h11);
        cfg_we = 1'b1; cfg_a = 8'd2; cfg_b = 8'd3;
        cfg_strength = 32'd950; cfg_coupling = 32'd90; cfg_mask = 8'hFF;
        bus.req_valid = 1'b1; bus.req_a = 8'd2; bus.req_b = 8'd3; bus.req_tag = 4'd10;
        step();
        cfg_we = 1'b0; bus.req_valid = 1'b0;
        check("collision_old", dut_rsp(), {32'd111, 32'd11, 8'h11, 4'd10, 1'b1, 1'b0});
        model_count(model_lookup(2, 3, 4'd10));
        model_write(2, 3, '{32'd950, 32'd90, 8'hFF});
        lookup_model("collision_new", 2, 3, 4'd11);
        check("collision_new_val", dut_rsp(), {32'd950, 32'd90, 8'hFF, 4'd11, 1'b1, 1'b0});

        // Clear from IDLE.
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        check("clear_busy", busy, 1);
        measure_busy("clear_cycles");
        m_tab.delete();
        lookup_model("after_clear", 1, 2, 4'd12);
        check("after_clear_hit", bus.rsp_hit, 0);

        // Restart mid-sweep; a write during the sweep must be ignored.
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cfg_we = (i == 10); cfg_a = 8'd0; cfg_b = 8'd0;
            cfg_strength = 32'd7; cfg_coupling = 32'd7; cfg_mask = 8'h07;
            step();
        end
        cfg_we = 1'b0;
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        check("restart_busy", busy, 1);
        measure_busy("restart_cycles");
        lookup_model("sweep_write_dropped", 0, 0, 4'd13);
        step();

        // Randomized traffic against the model.
        m_rsp_valid = 1'b0;
        m_rsp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ra = int'($urandom_range(0, 9)); rb = int'($urandom_range(0, 9));
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.req_a = 8'(ra); bus.req_b = 8'(rb); bus.req_tag = 4'($urandom);
            cfg_we = ($urandom_range(0, 2) == 0);
            cfg_a = 8'($urandom_range(0, 9)); cfg_b = 8'($urandom_range(0, 9));
            cfg_strength = $urandom; cfg_coupling = $urandom; cfg_mask = 8'($urandom);
            #1;
            acc = !m_rsp_valid || bus.rsp_ready;
            check("rand_ready", bus.req_ready, acc);
            if (bus.req_valid && acc) begin
                m_rsp = model_lookup(ra, rb, bus.req_tag);
                m_rsp_valid = 1'b1;
                model_count(m_rsp);
            end else if (bus.rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
            if (cfg_we) model_write(int'(cfg_a), int'(cfg_b), '{cfg_strength, cfg_coupling, cfg_mask});
            step();
            check("rand_valid", bus.rsp_valid, m_rsp_valid);
            if (m_rsp_valid) check("rand_rsp", dut_rsp(), m_rsp);
            check("rand_lookup_cnt", lookup_cnt, e_lk);
            check("rand_miss_cnt", miss_cnt, e_ms);
        end
        cfg_we = 1'b0; bus.req_valid = 1'b0;

        check("sat_lookup_cnt", lookup_cnt_s, (e_lk > 7) ? 7 : e_lk);
        check("sat_miss_cnt", miss_cnt_s, (e_ms > 7) ? 7 : e_ms);

        // Reset with a response pending.
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_a = 8'd1; bus.req_b = 8'd1;
        step();
        bus.req_valid = 1'b0;
        check("pre_reset_valid", bus.rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", bus.rsp_valid, 0);
        check("midreset_rsp_data", dut_rsp(), 0);
        check("midreset_lookup_cnt", lookup_cnt, 0);
        check("midreset_miss_cnt", miss_cnt, 0);
        check("midreset_busy", busy, 1);
        #1 rst_n = 1'b1;
        measure_busy("midreset_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
